// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one ULA datapath between two requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (ALU settles)
// -> RESP (response held until consumed).
// Compile-time option: define ULA_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins contention); otherwise round-robin.
module ula_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_q;
  logic             id_q;
  logic [OPW-1:0]   alu_opcode_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_overflow_q;
  logic             rsp_carry_q;

  logic             grant_d;
  logic             grant_id_d;
  logic [OPW-1:0]   opcode_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  // Pick the requester to grant this cycle and mux its operation
  always_comb begin
    grant_d = (state_q == IDLE) & (req0_valid | req1_valid);
    if (req0_valid & req1_valid) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      grant_id_d = 1'b0;
`else
      grant_id_d = ~last_q;
`endif
    end else begin
      grant_id_d = req1_valid;
    end
    opcode_d = grant_id_d ? req1_opcode : req0_opcode;
    a_d      = grant_id_d ? req1_a      : req0_a;
    b_d      = grant_id_d ? req1_b      : req0_b;
  end

  assign req0_ready = grant_d & ~grant_id_d;
  assign req1_ready = grant_d &  grant_id_d;

  // Control FSM with registered ALU drive and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      id_q           <= 1'b0;
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            alu_opcode_q <= opcode_d;
            alu_a_q      <= a_d;
            alu_b_q      <= b_d;
            id_q         <= grant_id_d;
            last_q       <= grant_id_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q     <= alu_out;
          rsp_zero_q     <= (alu_out == '0);
          rsp_overflow_q <= alu_overflow;
          rsp_carry_q    <= alu_carry;
          rsp_id_q       <= id_q;
          rsp_valid_q    <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_carry    = rsp_carry_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Testbench for ula_arbiter: vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_ula_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
  logic        alu_overflow, alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_carry;
  logic [31:0] rsp_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ula_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry)
  );

  // Behavioural ALU: {overflow, carry, result}
  function automatic logic [33:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd5: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd23: begin
        r = a | b;
        c = 1'b0;
        v = 1'b0;
      end
      default: begin
        r = a ^ b;
        c = op[0];
        v = op[1];
      end
    endcase
    return {v, c, r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_out} = alu_model(alu_opcode, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic v);
    if (id) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_zero"}, rsp_zero, 0);
    chk({tag, "_rsp_overflow"}, rsp_overflow, 0);
    chk({tag, "_rsp_carry"}, rsp_carry, 0);
  endtask

  // Leaves the bench at a falling edge with reset released
  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 0;
    repeat (2) @(negedge clock);
    #1 chk_reset("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [31:0] a, b, data;
    logic        zero, ovf, carry;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        zero, ovf, carry;
  } rsp_t;

  vec_t vecs[6];

  task automatic apply_vec(input vec_t v);
    logic found;
    found = 0;
    @(negedge clock);
    drive_req(v.id, v.op, v.a, v.b, 1'b1);
    #1;
    for (int c = 0; c < 20; c++) begin
      if ((v.id ? req1_ready : req0_ready) === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clock); #1;
    end
    chk("vec_ready", found, 1);
    chk("vec_other_ready", v.id ? req0_ready : req1_ready, 0);
    @(negedge clock);
    drive_req(v.id, v.op, v.a, v.b, 1'b0);
    #1;
    chk("vec_exec_rsp_valid", rsp_valid, 0);
    chk("vec_alu_opcode", alu_opcode, v.op);
    chk("vec_alu_a", alu_a, v.a);
    chk("vec_alu_b", alu_b, v.b);
    @(negedge clock); #1;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, v.id);
    chk("vec_rsp_data", rsp_data, v.data);
    chk("vec_rsp_zero", rsp_zero, v.zero);
    chk("vec_rsp_overflow", rsp_overflow, v.ovf);
    chk("vec_rsp_carry", rsp_carry, v.carry);
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;
    #1 chk("vec_rsp_done", rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int    g_cnt, both_seen;
    int    g_cyc[4];
    logic  g_id[4];
    logic  exp_id;
    // random-phase state
    logic  p[2];
    logic [4:0]  m_op[2];
    logic [31:0] m_a[2], m_b[2];
    logic  g[2];
    logic  last_m, r0, r1, gid, pick, done;
    logic [33:0] f;
    int    issued;
    rsp_t  exp_q[$];
    rsp_t  e;

    vecs[0] = '{1'b0, 5'd0,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd5,  32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h8000_0000, 32'h8000_0000, 32'd0,      1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 5'd23, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd3,  32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'd0,      1'b1, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Continuous contention with rsp_ready held high
    do_reset();
    drive_req(1'b0, 5'd0, 32'd1, 32'd2, 1'b1);
    drive_req(1'b1, 5'd0, 32'd3, 32'd4, 1'b1);
    rsp_ready = 1;
    g_cnt = 0; both_seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_seen++;
      if (req0_ready || req1_ready) begin
        if (g_cnt < 4) begin
          g_cyc[g_cnt] = cyc;
          g_id[g_cnt]  = req1_ready;
        end
        g_cnt++;
      end
      @(negedge clock);
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_grant_count", g_cnt, 4);
    chk("cont_both_ready", both_seen, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      chk("cont_grant_cycle", g_cyc[k], 3 * k);
      chk("cont_grant_id", g_id[k], exp_id);
    end
    repeat (3) @(negedge clock);
    rsp_ready = 0;

    // Back-pressure on the response while requester 1 waits
    @(negedge clock);
    drive_req(1'b0, 5'd0, 32'd3, 32'd4, 1'b1);
    #1 chk("bp_req0_ready", req0_ready, 1);
    @(negedge clock);
    drive_req(1'b0, 5'd0, 32'd3, 32'd4, 1'b0);
    drive_req(1'b1, 5'd5, 32'd10, 32'd4, 1'b1);
    #1 chk("bp_exec_req1_ready", req1_ready, 0);
    @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 32'd7);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_req1_ready", req1_ready, 0);
      @(negedge clock);
    end
    rsp_ready = 1;
    #1 chk("bp_hs_req1_ready", req1_ready, 0);
    @(negedge clock);
    rsp_ready = 0;
    #1;
    chk("bp_after_rsp_valid", rsp_valid, 0);
    chk("bp_after_req1_ready", req1_ready, 1);
    @(negedge clock);
    req1_valid = 0;
    @(negedge clock); #1;
    chk("bp_r1_rsp_valid", rsp_valid, 1);
    chk("bp_r1_rsp_id", rsp_id, 1);
    chk("bp_r1_rsp_data", rsp_data, 32'd6);
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;

    // Reset during EXEC discards the operation
    @(negedge clock);
    drive_req(1'b0, 5'd23, 32'hF0, 32'h0F, 1'b1);
    #1 chk("mid_req0_ready", req0_ready, 1);
    @(negedge clock);
    req0_valid = 0;
    #1 chk("mid_alu_a", alu_a, 32'hF0);
    reset = 1;
    #1 chk_reset("mid_reset");
    @(negedge clock);
    reset = 0;
    rsp_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1 chk("mid_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 0;

    // Randomized traffic against a transaction-level model
    do_reset();
    p[0] = 0; p[1] = 0; g[0] = 0; g[1] = 0;
    last_m = 1; issued = 0; done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clock);
      for (int r = 0; r < 2; r++) begin
        if (g[r]) p[r] = 0;
        g[r] = 0;
        if (!p[r] && issued < 40 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0: m_op[r] = 5'd0;
            1: m_op[r] = 5'd5;
            2: m_op[r] = 5'd23;
            default: m_op[r] = 5'($urandom);
          endcase
          m_a[r] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
          m_b[r] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
          p[r] = 1;
          issued++;
        end
      end
      drive_req(1'b0, m_op[0], m_a[0], m_b[0], p[0]);
      drive_req(1'b1, m_op[1], m_a[1], m_b[1], p[1]);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) chk("rnd_single_ready", 1, 0);
      else if (r0 || r1) begin
        gid = r1;
`ifdef ULA_ARB_FIXED_PRIO_EN
        pick = (p[0] && p[1]) ? 1'b0 : p[1];
`else
        pick = (p[0] && p[1]) ? ~last_m : p[1];
`endif
        chk("rnd_grant_pending", p[gid], 1);
        chk("rnd_grant_id", gid, pick);
        f = alu_model(m_op[gid], m_a[gid], m_b[gid]);
        e.id = gid; e.data = f[31:0]; e.zero = (f[31:0] == 32'd0);
        e.ovf = f[33]; e.carry = f[32];
        exp_q.push_back(e);
        last_m = gid;
        g[gid] = 1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_rsp_id", rsp_id, e.id);
          chk("rnd_rsp_data", rsp_data, e.data);
          chk("rnd_rsp_zero", rsp_zero, e.zero);
          chk("rnd_rsp_overflow", rsp_overflow, e.ovf);
          chk("rnd_rsp_carry", rsp_carry, e.carry);
        end
      end
      done = (issued == 40) && !p[0] && !p[1] && !g[0] && !g[1] && (exp_q.size() == 0);
    end
    chk("rnd_all_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares the single `ULA` datapath between two requesters, such as the execute stage and the address/branch unit. The arbiter accepts one operation at a time through a valid/ready handshake and drives the ALU operand and opcode registers. It captures the result and flags one cycle later and returns them with a response handshake tagged by requester ID. Fairness is round-robin by default; fixed priority is selectable at compile time.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `OPW`, 5, opcode width

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_opcode` in OPW, `req0_a` in WIDTH, `req0_b` in WIDTH: requester 0 operation.
- `req1_valid` / `req1_ready` / `req1_opcode` / `req1_a` / `req1_b`: same, requester 1.
- `alu_opcode` out OPW, `alu_a` out WIDTH, `alu_b` out WIDTH: registered drive to ALU.
- `alu_out` in WIDTH, `alu_overflow` in 1, `alu_carry` in 1: ALU result and flags.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_data` out WIDTH: captured `alu_out`.
- `rsp_zero` out 1: 1 when captured `alu_out` is all zeros; computed locally, ALU zero flag is not used.
- `rsp_overflow` out 1, `rsp_carry` out 1: captured flags.

## Operation
- FSM states:
  - IDLE: if any `reqN_valid`, grant one requester.
    - Assert its `reqN_ready` combinationally for that cycle.
    - Load `alu_opcode`, `alu_a`, `alu_b` and the granted ID at the clock edge.
    - Go to EXEC.
  - EXEC: operands stable at the ALU for one full cycle. At the end-of-cycle edge, capture `alu_out`, the flags and the zero compare into the response registers. Go to RESP.
  - RESP: `rsp_valid`=1 with the registered response. On `rsp_valid & rsp_ready`, go to IDLE.
- `reqN_ready` is only ever asserted in IDLE, for at most one requester per cycle, and only when that requester's valid is high.
- Round-robin: register `last` holds the ID of the last grant.
  - Both valid: grant `~last`.
  - One valid: grant it.
  - `last` updates on every grant.
- `alu_*` registers hold their value outside IDLE grants, keeping the ALU input stable.
- Response registers are held unchanged while `rsp_valid`=1 and `rsp_ready`=0.
- Opcodes pass through unchecked; undefined opcodes yield whatever the ALU drives.

## Timing
- Reset values:
  - state=IDLE, `last`=1, so requester 0 wins the first contention.
  - `alu_opcode`=0, `alu_a`=0, `alu_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_overflow`=0, `rsp_carry`=0.
  - `req0_ready`=0, `req1_ready`=0.
- Latency: accept at edge T, EXEC during T+1, `rsp_valid` high from T+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with `rsp_ready`=1). The next accept is possible in the cycle after the response handshake.
- Requesters not granted keep `valid` asserted; the arbiter never drops a waiting request.
- Simultaneous valid in IDLE: exactly one ready, chosen as above.
- `rsp_ready` held high before `rsp_valid` is harmless; the handshake completes in the first RESP cycle.
- Reset asserted mid-operation: immediate return to reset values. The in-flight operation is discarded and no response is produced.

## Configuration
- `ULA_ARB_FIXED_PRIO_EN` defined: requester 0 always wins when both are valid. `last` is still maintained but not used for selection.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset, then `req0` opcode=00000, A=5, B=7 → `req0_ready` pulses 1 cycle. Two cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=12, `rsp_zero`=0.
- `req1` opcode=00101 (sub), A=9, B=9 → `rsp_data`=0, `rsp_zero`=1, `rsp_id`=1.
- Both valid continuously, `rsp_ready`=1, with the macro undefined → grants alternate 0,1,0,1 over four operations, one accept every 3 cycles. With the macro defined → four grants to requester 0 and none to requester 1.
- `rsp_ready`=0 for 5 cycles after the response, with `req1_valid`=1 → `rsp_*` stable, `req1_ready` stays 0. `rsp_ready`=1 → handshake, then `req1` accepted the next cycle.
- `reset` pulsed during EXEC of opcode 10111 (or) A=0xF0, B=0x0F → all outputs return to reset values and no `rsp_valid` follows.
- ALU model drives `alu_overflow`=1 and `alu_carry`=1 for A=0x80000000, B=0x80000000 add → `rsp_overflow`=1, `rsp_carry`=1, `rsp_data`=0, `rsp_zero`=1.
